// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: hardwired fetch/decode/execute control unit for the datapath.
// Walks PC/MAR/MDR fetch, decodes IR and issues register/ALU strobes for
// register-register ALU instructions, with a memory-ready handshake and halt.
// Optional feature macro: MULDIV_EN (mul/div decode, T4W/T6 states, HI/LO writeback).
module alu_control_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic [31:0]         IR,
  input  logic                mem_rdy,
  input  logic                alu_done,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                ZLowin,
  output logic                ZHighin,
  output logic                ZLowout,
  output logic                ZHighout,
  output logic                HIin,
  output logic                LOin,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [OP_W-1:0]     OP,
  output logic                halted
);

  typedef enum logic [3:0] {
    S_RST,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
`ifdef MULDIV_EN
    S_T4W,
    S_T6,
`endif
    S_T5,
    S_HALT
  } state_t;

  // Register numbers at or above this limit make the instruction a nop.
  localparam logic [4:0] REG_LIMIT = 5'(NUM_REGS);

  state_t state_q, state_d;

  logic [4:0] ir_opcode;
  logic [3:0] ir_ra, ir_rb, ir_rc;
  logic       is_rtype, is_muldiv, is_halt, fields_ok, dec_valid, capture;

  logic [3:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [4:0] opsel_q, opsel_d;
  logic       muldiv_q, muldiv_d;

  logic pc_out_q, pc_out_d, mar_in_q, mar_in_d, inc_pc_q, inc_pc_d;
  logic read_q, read_d, t1_q, t1_d, mdr_out_q, mdr_out_d, ir_in_q, ir_in_d;
  logic y_in_q, y_in_d, zlow_in_q, zlow_in_d, zhigh_in_q, zhigh_in_d;
  logic zlow_out_q, zlow_out_d, halted_q, halted_d;
  logic [NUM_REGS-1:0] rin_q, rin_d, rout_q, rout_d;
  logic [OP_W-1:0]     op_out_q, op_out_d;
`ifdef MULDIV_EN
  logic zhigh_out_q, zhigh_out_d, hi_in_q, hi_in_d, lo_in_q, lo_in_d;
  logic [14:0] unused_ir_bits;
`else
  logic [15:0] unused_ir_bits;
`endif

  assign ir_opcode = IR[31:27];
  assign ir_ra     = IR[26:23];
  assign ir_rb     = IR[22:19];
  assign ir_rc     = IR[18:15];
`ifdef MULDIV_EN
  assign unused_ir_bits = IR[14:0];
`else
  assign unused_ir_bits = {alu_done, IR[14:0]};
`endif

  function automatic logic [NUM_REGS-1:0] one_hot(input logic [3:0] idx);
    logic [NUM_REGS-1:0] v;
    for (int i = 0; i < NUM_REGS; i++) begin
      v[i] = ({1'b0, idx} == 5'(i));
    end
    return v;
  endfunction

  // Classify the instruction currently presented on IR.
  always_comb begin
    is_rtype  = (ir_opcode >= 5'd3) && (ir_opcode <= 5'd10);
`ifdef MULDIV_EN
    is_muldiv = (ir_opcode == 5'd15) || (ir_opcode == 5'd16);
`else
    is_muldiv = 1'b0;
`endif
    is_halt   = (ir_opcode == 5'd27);
    fields_ok = ({1'b0, ir_ra} < REG_LIMIT) && ({1'b0, ir_rb} < REG_LIMIT) &&
                ({1'b0, ir_rc} < REG_LIMIT);
    dec_valid = (is_rtype || is_muldiv) && fields_ok;
  end

  // Next-state selection for the fetch/execute sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = mem_rdy ? S_T2 : S_T1;
      S_T2: begin
        if (is_halt)        state_d = S_HALT;
        else if (dec_valid) state_d = S_T3;
        else                state_d = S_T0;
      end
      S_T3:   state_d = S_T4;
`ifdef MULDIV_EN
      S_T4:   state_d = (muldiv_q && !alu_done) ? S_T4W : S_T5;
      S_T4W:  state_d = alu_done ? S_T5 : S_T4W;
      S_T5:   state_d = muldiv_q ? S_T6 : S_T0;
      S_T6:   state_d = S_T0;
`else
      S_T4:   state_d = S_T5;
      S_T5:   state_d = S_T0;
`endif
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Latch the decoded fields as the sequencer enters T3.
  always_comb begin
    capture  = (state_q == S_T2) && (state_d == S_T3);
    ra_d     = capture ? ir_ra : ra_q;
    rb_d     = capture ? ir_rb : rb_q;
    rc_d     = capture ? ir_rc : rc_q;
    opsel_d  = capture ? (ir_opcode + 5'd1) : opsel_q;
    muldiv_d = capture ? is_muldiv : muldiv_q;
  end

  // Strobe pattern for the state being entered, registered so outputs are Moore.
  always_comb begin
    pc_out_d = 1'b0; mar_in_d = 1'b0; inc_pc_d = 1'b0; read_d = 1'b0; t1_d = 1'b0;
    mdr_out_d = 1'b0; ir_in_d = 1'b0; y_in_d = 1'b0; zlow_in_d = 1'b0;
    zhigh_in_d = 1'b0; zlow_out_d = 1'b0; halted_d = 1'b0;
    rin_d = '0; rout_d = '0; op_out_d = '0;
`ifdef MULDIV_EN
    zhigh_out_d = 1'b0; hi_in_d = 1'b0; lo_in_d = 1'b0;
`endif
    case (state_d)
      S_T0: begin
        pc_out_d = 1'b1; mar_in_d = 1'b1; inc_pc_d = 1'b1;
        zlow_in_d = 1'b1; zhigh_in_d = 1'b1;
      end
      S_T1: begin
        read_d = 1'b1; t1_d = 1'b1;
      end
      S_T2: begin
        mdr_out_d = 1'b1; ir_in_d = 1'b1;
      end
      S_T3: begin
        rout_d = one_hot(rb_d); y_in_d = 1'b1;
      end
      S_T4: begin
        rout_d = one_hot(rc_d); op_out_d = OP_W'(opsel_d);
        zlow_in_d = 1'b1; zhigh_in_d = 1'b1;
      end
`ifdef MULDIV_EN
      S_T4W: op_out_d = OP_W'(opsel_d);
      S_T6: begin
        zhigh_out_d = 1'b1; hi_in_d = 1'b1;
      end
`endif
      S_T5: begin
        zlow_out_d = 1'b1; op_out_d = OP_W'(opsel_d);
`ifdef MULDIV_EN
        if (muldiv_d) lo_in_d = 1'b1;
        else          rin_d = one_hot(ra_d);
`else
        rin_d = one_hot(ra_d);
`endif
      end
      S_HALT: halted_d = 1'b1;
      default: ;
    endcase
  end

  // State, decoded fields and registered strobes; Clear low aborts everything.
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state_q <= S_RST;
      ra_q <= '0; rb_q <= '0; rc_q <= '0; opsel_q <= '0; muldiv_q <= 1'b0;
      pc_out_q <= 1'b0; mar_in_q <= 1'b0; inc_pc_q <= 1'b0; read_q <= 1'b0;
      t1_q <= 1'b0; mdr_out_q <= 1'b0; ir_in_q <= 1'b0; y_in_q <= 1'b0;
      zlow_in_q <= 1'b0; zhigh_in_q <= 1'b0; zlow_out_q <= 1'b0; halted_q <= 1'b0;
      rin_q <= '0; rout_q <= '0; op_out_q <= '0;
`ifdef MULDIV_EN
      zhigh_out_q <= 1'b0; hi_in_q <= 1'b0; lo_in_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ra_q <= ra_d; rb_q <= rb_d; rc_q <= rc_d; opsel_q <= opsel_d; muldiv_q <= muldiv_d;
      pc_out_q <= pc_out_d; mar_in_q <= mar_in_d; inc_pc_q <= inc_pc_d; read_q <= read_d;
      t1_q <= t1_d; mdr_out_q <= mdr_out_d; ir_in_q <= ir_in_d; y_in_q <= y_in_d;
      zlow_in_q <= zlow_in_d; zhigh_in_q <= zhigh_in_d; zlow_out_q <= zlow_out_d;
      halted_q <= halted_d;
      rin_q <= rin_d; rout_q <= rout_d; op_out_q <= op_out_d;
`ifdef MULDIV_EN
      zhigh_out_q <= zhigh_out_d; hi_in_q <= hi_in_d; lo_in_q <= lo_in_d;
`endif
    end
  end

  assign PCout   = pc_out_q;
  assign MARin   = mar_in_q;
  assign IncPC   = inc_pc_q;
  assign Read    = read_q;
  assign PCin    = t1_q & mem_rdy;
  assign MDRin   = t1_q & mem_rdy;
  assign MDRout  = mdr_out_q;
  assign IRin    = ir_in_q;
  assign Yin     = y_in_q;
  assign ZLowin  = zlow_in_q;
  assign ZHighin = zhigh_in_q;
  assign ZLowout = zlow_out_q | (t1_q & mem_rdy);
  assign Rin     = rin_q;
  assign Rout    = rout_q;
  assign OP      = op_out_q;
  assign halted  = halted_q;
`ifdef MULDIV_EN
  assign ZHighout = zhigh_out_q;
  assign HIin     = hi_in_q;
  assign LOin     = lo_in_q;
`else
  assign ZHighout = 1'b0;
  assign HIin     = 1'b0;
  assign LOin     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb_alu_control_sequencer: directed per-cycle stimulus with a scoreboard of
// hand-written expected strobe patterns, checked by a separate monitor.
module tb_alu_control_sequencer;

  localparam int NR = 8;

  typedef struct packed {
    logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
    logic zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in, lo_in, halted;
    logic [NR-1:0] rin;
    logic [NR-1:0] rout;
    logic [4:0]    op;
  } outs_t;

  logic Clock, Clear, mem_rdy, alu_done;
  logic [31:0] IR;
  logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin, halted;
  logic [NR-1:0] Rin, Rout;
  logic [4:0] OP;

  outs_t exp_q[$];
  string name_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  alu_control_sequencer #(.NUM_REGS(NR), .OP_W(5)) dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .mem_rdy(mem_rdy), .alu_done(alu_done),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowin(ZLowin),
    .ZHighin(ZHighin), .ZLowout(ZLowout), .ZHighout(ZHighout), .HIin(HIin),
    .LOin(LOin), .Rin(Rin), .Rout(Rout), .OP(OP), .halted(halted)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Expected strobe patterns for each sequencer step.
  function automatic outs_t o_zero();
    outs_t o = '0;
    return o;
  endfunction
  function automatic outs_t o_t0();
    outs_t o = '0;
    o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1; o.zlow_in = 1'b1; o.zhigh_in = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_t1(input logic rdy);
    outs_t o = '0;
    o.read = 1'b1; o.pc_in = rdy; o.mdr_in = rdy; o.zlow_out = rdy;
    return o;
  endfunction
  function automatic outs_t o_t2();
    outs_t o = '0;
    o.mdr_out = 1'b1; o.ir_in = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_t3(input logic [NR-1:0] rout);
    outs_t o = '0;
    o.rout = rout; o.y_in = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_t4(input logic [NR-1:0] rout, input logic [4:0] op);
    outs_t o = '0;
    o.rout = rout; o.op = op; o.zlow_in = 1'b1; o.zhigh_in = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_t4w(input logic [4:0] op);
    outs_t o = '0;
    o.op = op;
    return o;
  endfunction
  function automatic outs_t o_t5(input logic [NR-1:0] rin, input logic [4:0] op, input logic lo);
    outs_t o = '0;
    o.zlow_out = 1'b1; o.rin = rin; o.op = op; o.lo_in = lo;
    return o;
  endfunction
  function automatic outs_t o_t6();
    outs_t o = '0;
    o.zhigh_out = 1'b1; o.hi_in = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_halt();
    outs_t o = '0;
    o.halted = 1'b1;
    return o;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {opc, ra, rb, rc, 15'd0};
  endfunction

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic applyStimulus(input logic clr, input logic [31:0] ir, input logic rdy,
                               input logic done, input outs_t exp, input string name);
    Clear = clr; IR = ir; mem_rdy = rdy; alu_done = done;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input outs_t exp, input string name);
    outs_t act;
    act.pc_out = PCout; act.mar_in = MARin; act.inc_pc = IncPC; act.pc_in = PCin;
    act.read = Read; act.mdr_in = MDRin; act.mdr_out = MDRout; act.ir_in = IRin;
    act.y_in = Yin; act.zlow_in = ZLowin; act.zhigh_in = ZHighin; act.zlow_out = ZLowout;
    act.zhigh_out = ZHighout; act.hi_in = HIin; act.lo_in = LOin; act.halted = halted;
    act.rin = Rin; act.rout = Rout; act.op = OP;
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation mid-cycle.
  always @(negedge Clock) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front(), name_q.pop_front());
  end

  task automatic run_fetch(input logic [31:0] ir, input int stall, input string tag);
    applyStimulus(1'b1, ir, 1'b1, 1'b0, o_t0(), {tag, "_t0"});
    for (int i = 0; i < stall; i++) applyStimulus(1'b1, ir, 1'b0, 1'b0, o_t1(1'b0), {tag, "_t1_wait"});
    applyStimulus(1'b1, ir, 1'b1, 1'b0, o_t1(1'b1), {tag, "_t1_rdy"});
    applyStimulus(1'b1, ir, 1'b1, 1'b0, o_t2(), {tag, "_t2"});
  endtask

  task automatic run_rtype(input logic [31:0] ir, input int stall, input logic [NR-1:0] rb_oh,
                           input logic [NR-1:0] rc_oh, input logic [NR-1:0] ra_oh,
                           input logic [4:0] op, input string tag);
    run_fetch(ir, stall, tag);
    applyStimulus(1'b1, ir, 1'b1, 1'b0, o_t3(rb_oh), {tag, "_t3"});
    applyStimulus(1'b1, ir, 1'b1, 1'b0, o_t4(rc_oh, op), {tag, "_t4"});
    applyStimulus(1'b1, ir, 1'b1, 1'b0, o_t5(ra_oh, op, 1'b0), {tag, "_t5"});
  endtask

  initial begin
    logic [31:0] add_ir, mul_ir, div_ir;
    add_ir = 32'h1822_8000;
    mul_ir = mk_ir(5'b01111, 4'd2, 4'd3, 4'd4);
    div_ir = mk_ir(5'b10000, 4'd5, 4'd6, 4'd7);
    Clear = 1'b0; IR = '0; mem_rdy = 1'b0; alu_done = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    applyStimulus(1'b0, add_ir, 1'b1, 1'b0, o_zero(), "reset_state");
    applyStimulus(1'b1, add_ir, 1'b1, 1'b0, o_zero(), "reset_release");

    // add R0 = R4 + R5, then sub R1 = R2 - R3 with a three-cycle memory stall
    run_rtype(add_ir, 0, 8'h10, 8'h20, 8'h01, 5'b00100, "add");
    run_rtype(mk_ir(5'b00100, 4'd1, 4'd2, 4'd3), 3, 8'h04, 8'h08, 8'h02, 5'b00101, "sub_stall");
    // top of the R-type range (rol) with the highest legal register numbers
    run_rtype(mk_ir(5'b01010, 4'd7, 4'd6, 4'd0), 0, 8'h40, 8'h01, 8'h80, 5'b01011, "rol");
    run_rtype(mk_ir(5'b00101, 4'd3, 4'd7, 4'd1), 1, 8'h80, 8'h02, 8'h08, 5'b00110, "and");

    // opcodes just outside the R-type range, out-of-range registers, unknown opcode
    run_fetch(mk_ir(5'b01011, 4'd1, 4'd2, 4'd3), 0, "nop_op0b");
    run_fetch(mk_ir(5'b00010, 4'd1, 4'd2, 4'd3), 0, "nop_op02");
    run_fetch(mk_ir(5'b00011, 4'd0, 4'd9, 4'd1), 0, "bad_rb");
    run_fetch(mk_ir(5'b00011, 4'd8, 4'd1, 4'd2), 0, "bad_ra");
    run_fetch(mk_ir(5'b11111, 4'd1, 4'd2, 4'd3), 0, "nop_op1f");

`ifdef MULDIV_EN
    // mul R2 = R3 * R4, alu_done arrives late
    run_fetch(mul_ir, 0, "mul");
    applyStimulus(1'b1, mul_ir, 1'b1, 1'b0, o_t3(8'h08), "mul_t3");
    applyStimulus(1'b1, mul_ir, 1'b1, 1'b0, o_t4(8'h10, 5'b10000), "mul_t4");
    for (int i = 0; i < 31; i++) applyStimulus(1'b1, mul_ir, 1'b1, 1'b0, o_t4w(5'b10000), "mul_t4w");
    applyStimulus(1'b1, mul_ir, 1'b1, 1'b1, o_t4w(5'b10000), "mul_t4w_done");
    applyStimulus(1'b1, mul_ir, 1'b1, 1'b0, o_t5(8'h00, 5'b10000, 1'b1), "mul_t5");
    applyStimulus(1'b1, mul_ir, 1'b1, 1'b0, o_t6(), "mul_t6");
    // div with alu_done already high in T4 skips the wait state
    run_fetch(div_ir, 0, "div");
    applyStimulus(1'b1, div_ir, 1'b1, 1'b0, o_t3(8'h40), "div_t3");
    applyStimulus(1'b1, div_ir, 1'b1, 1'b1, o_t4(8'h80, 5'b10001), "div_t4");
    applyStimulus(1'b1, div_ir, 1'b1, 1'b0, o_t5(8'h00, 5'b10001, 1'b1), "div_t5");
    applyStimulus(1'b1, div_ir, 1'b1, 1'b0, o_t6(), "div_t6");
    // Clear during the mul wait abandons it; a late alu_done changes nothing
    run_fetch(mul_ir, 0, "mulrst");
    applyStimulus(1'b1, mul_ir, 1'b1, 1'b0, o_t3(8'h08), "mulrst_t3");
    applyStimulus(1'b1, mul_ir, 1'b1, 1'b0, o_t4(8'h10, 5'b10000), "mulrst_t4");
    applyStimulus(1'b1, mul_ir, 1'b1, 1'b0, o_t4w(5'b10000), "mulrst_t4w");
    applyStimulus(1'b0, mul_ir, 1'b1, 1'b0, o_t4w(5'b10000), "mulrst_clear_edge");
    applyStimulus(1'b1, mul_ir, 1'b1, 1'b1, o_zero(), "mulrst_rst");
`else
    // mul/div opcodes are nops in this build; Clear mid-instruction aborts it
    run_fetch(mul_ir, 0, "mul_nop");
    run_fetch(div_ir, 0, "div_nop");
    run_fetch(add_ir, 0, "addrst");
    applyStimulus(1'b0, add_ir, 1'b1, 1'b1, o_t3(8'h10), "addrst_clear_edge");
    applyStimulus(1'b1, add_ir, 1'b1, 1'b1, o_zero(), "addrst_rst");
`endif
    run_rtype(add_ir, 0, 8'h10, 8'h20, 8'h01, 5'b00100, "add_after_rst");

    // halt holds for 100 cycles regardless of handshake inputs
    run_fetch(mk_ir(5'b11011, 4'd0, 4'd0, 4'd0), 0, "halt");
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 32'h0, i[0], i[1], o_halt(), "halt_hold");
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, o_halt(), "halt_clear_edge");
    applyStimulus(1'b1, add_ir, 1'b1, 1'b0, o_zero(), "halt_rst");
    applyStimulus(1'b1, add_ir, 1'b1, 1'b0, o_t0(), "halt_restart_t0");

    repeat (2) @(posedge Clock);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
